// File: rtl/sbox_share_sched.sv
// Shares LANES combined forward/inverse AES S-boxes between the key expander (SubWord)
// and the round datapath (SubBytes/InvSubBytes), slicing each job into LANES-byte beats.

module sbox_mix #(
   parameter logic ZF_FWD = 1'b1
) (
   input  logic [7:0] din,
   input  logic       zf,
   output logic [7:0] dout
);
   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] s, r;
      s = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   logic       fwd;
   logic [7:0] inv_in, inv_out;

   assign fwd     = (zf == ZF_FWD);
   assign inv_in  = fwd ? din : (rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05);
   assign inv_out = gf_inv(inv_in);
   assign dout    = fwd ? (inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2) ^ rotl(inv_out, 3) ^
                           rotl(inv_out, 4) ^ 8'h63)
                        : inv_out;
endmodule

// state | meaning
// IDLE  | waiting for a request; readies may assert
// RUN   | issuing one LANES-byte beat per cycle
// WAIT  | final beat draining through the output pipe register
// RESP  | one-cycle response pulse to the job owner
module sbox_share_sched #(
   parameter int   LANES  = 4,
   parameter int   PIPE   = 1,
   parameter logic ZF_FWD = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ks_req_valid,
   output logic         ks_req_ready,
   input  logic [31:0]  ks_req_data,
   output logic         ks_rsp_valid,
   output logic [31:0]  ks_rsp_data,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic         st_req_inv,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   output logic [127:0] st_rsp_data,
   output logic         busy
);
   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("sbox_share_sched: LANES must be 1, 2 or 4");
   end
   if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
      $error("sbox_share_sched: PIPE must be 0 or 1");
   end

   localparam logic [3:0] KS_LAST = 4'(4 / LANES - 1);
   localparam logic [3:0] ST_LAST = 4'(16 / LANES - 1);

   typedef enum logic [1:0] {IDLE, RUN, WAIT, RESP} state_t;

   state_t                 state, state_nxt;
   logic                   last_grant_st, owner_st, mode_inv;
   logic                   grant_ks, grant_st, accept, zf, last_beat;
   logic [3:0]             beat;
   logic [15:0][7:0]       job, res, res_nxt;
   logic [LANES-1:0][7:0]  lane_in, lane_out, wr_data;
   logic                   wr_en;
   logic [3:0]             wr_beat;

   assign grant_ks     = ks_req_valid & (~st_req_valid | last_grant_st);
   assign grant_st     = st_req_valid & (~ks_req_valid | ~last_grant_st);
   assign ks_req_ready = ~rst & (state == IDLE) & grant_ks;
   assign st_req_ready = ~rst & (state == IDLE) & grant_st;
   assign accept       = (ks_req_valid & ks_req_ready) | (st_req_valid & st_req_ready);
   assign busy         = (state != IDLE);
   assign ks_rsp_valid = (state == RESP) & ~owner_st;
   assign st_rsp_valid = (state == RESP) & owner_st;
   assign zf           = mode_inv ? ~ZF_FWD : ZF_FWD;
   assign last_beat    = (beat == (owner_st ? ST_LAST : KS_LAST));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last_beat) state_nxt = (PIPE == 1) ? WAIT : RESP;
         WAIT:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_in[j] = job[4'(int'(beat) * LANES + j)];
      sbox_mix #(.ZF_FWD(ZF_FWD)) u_sbox (
         .din  (lane_in[j]),
         .zf   (zf),
         .dout (lane_out[j])
      );
   end

   if (PIPE == 1) begin : g_pipe
      logic                  pipe_vld;
      logic [3:0]            pipe_beat;
      logic [LANES-1:0][7:0] pipe_data;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pipe_vld  <= 1'b0;
            pipe_beat <= '0;
            pipe_data <= '0;
         end else begin
            pipe_vld  <= (state == RUN);
            pipe_beat <= beat;
            pipe_data <= lane_out;
         end
      end
      assign wr_en   = pipe_vld;
      assign wr_beat = pipe_beat;
      assign wr_data = pipe_data;
   end else begin : g_nopipe
      assign wr_en   = (state == RUN);
      assign wr_beat = beat;
      assign wr_data = lane_out;
   end

   // result byte i is owned by lane i%LANES in beat i/LANES
   for (genvar i = 0; i < 16; i++) begin : g_res
      assign res_nxt[i] = (wr_en && wr_beat == 4'(i / LANES)) ? wr_data[i % LANES] : res[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant_st <= 1'b1;
         owner_st      <= 1'b0;
         mode_inv      <= 1'b0;
         job           <= '0;
         res           <= '0;
         beat          <= '0;
         ks_rsp_data   <= '0;
         st_rsp_data   <= '0;
      end else begin
         state <= state_nxt;
         res   <= res_nxt;
         beat  <= (state == RUN) ? beat + 4'd1 : 4'd0;
         if (accept) begin
            last_grant_st <= grant_st;
            owner_st      <= grant_st;
            mode_inv      <= grant_st & st_req_inv;
            job           <= grant_st ? st_req_data : {96'b0, ks_req_data};
         end
         if (state != RESP && state_nxt == RESP) begin
            if (owner_st) st_rsp_data <= res_nxt;
            else          ks_rsp_data <= res_nxt[3:0];
         end
      end
   end
endmodule

// File: tb/tb_sbox_share_sched.sv
// Scoreboard bench for sbox_share_sched: a LANES=4/PIPE=1 instance and a LANES=1/PIPE=0 instance.
// Channels: 0 = ks (a), 1 = st (a), 2 = ks (b), 3 = st (b).

module tb_sbox_share_sched;
   localparam logic [127:0] SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] SBX = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [127:0] B53 = {16{8'h53}};
   localparam logic [127:0] BED = {16{8'hed}};
   localparam logic [127:0] B52 = {16{8'h52}};
   localparam logic [127:0] B48 = {16{8'h48}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         ks_req_valid_a, ks_req_ready_a, ks_rsp_valid_a, st_req_valid_a, st_req_ready_a;
   logic         st_req_inv_a, st_rsp_valid_a, busy_a;
   logic [31:0]  ks_req_data_a, ks_rsp_data_a;
   logic [127:0] st_req_data_a, st_rsp_data_a;
   logic         ks_req_valid_b, ks_req_ready_b, ks_rsp_valid_b, st_req_valid_b, st_req_ready_b;
   logic         st_req_inv_b, st_rsp_valid_b, busy_b;
   logic [31:0]  ks_req_data_b, ks_rsp_data_b;
   logic [127:0] st_req_data_b, st_rsp_data_b;

   sbox_share_sched #(.LANES(4), .PIPE(1), .ZF_FWD(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .ks_req_valid(ks_req_valid_a), .ks_req_ready(ks_req_ready_a), .ks_req_data(ks_req_data_a),
      .ks_rsp_valid(ks_rsp_valid_a), .ks_rsp_data(ks_rsp_data_a),
      .st_req_valid(st_req_valid_a), .st_req_ready(st_req_ready_a), .st_req_inv(st_req_inv_a),
      .st_req_data(st_req_data_a), .st_rsp_valid(st_rsp_valid_a), .st_rsp_data(st_rsp_data_a),
      .busy(busy_a)
   );

   sbox_share_sched #(.LANES(1), .PIPE(0), .ZF_FWD(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .ks_req_valid(ks_req_valid_b), .ks_req_ready(ks_req_ready_b), .ks_req_data(ks_req_data_b),
      .ks_rsp_valid(ks_rsp_valid_b), .ks_rsp_data(ks_rsp_data_b),
      .st_req_valid(st_req_valid_b), .st_req_ready(st_req_ready_b), .st_req_inv(st_req_inv_b),
      .st_req_data(st_req_data_b), .st_rsp_valid(st_rsp_valid_b), .st_rsp_data(st_rsp_data_b),
      .busy(busy_b)
   );

   typedef struct {
      logic [127:0] data;
      int           due;
   } exp_t;

   exp_t sb[4][$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int ch);
      case (ch)
         0:       return ks_req_ready_a;
         1:       return st_req_ready_a;
         2:       return ks_req_ready_b;
         default: return st_req_ready_b;
      endcase
   endfunction

   task automatic set_req(input int ch, input logic v, input logic inv, input logic [127:0] d);
      case (ch)
         0: begin ks_req_valid_a = v; ks_req_data_a = d[31:0]; end
         1: begin st_req_valid_a = v; st_req_inv_a = inv; st_req_data_a = d; end
         2: begin ks_req_valid_b = v; ks_req_data_b = d[31:0]; end
         default: begin st_req_valid_b = v; st_req_inv_b = inv; st_req_data_b = d; end
      endcase
   endtask

   // Presents a request, records the expected response at accept, then drops valid and
   // scrambles data/inv in the following cycle so a job that re-reads its inputs is caught.
   task automatic send(input int ch, input logic inv, input logic [127:0] d,
                       input logic [127:0] exp, input int lat, output int t_acc);
      set_req(ch, 1'b1, inv, d);
      #1;
      for (int i = 0; i < 100 && !rdy(ch); i++) begin
         @(negedge clk);
         #1;
      end
      if (!rdy(ch)) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout ch%0d: ready got 0 expected 1", ch);
         t_acc = -1;
         set_req(ch, 1'b0, inv, d);
      end else begin
         t_acc = cyc;
         sb[ch].push_back('{exp, cyc + lat});
         @(negedge clk);
         set_req(ch, 1'b0, ~inv, ~d);
      end
   endtask

   task automatic mon(input int ch, input logic [127:0] d, input logic bz);
      exp_t e;
      if (sb[ch].size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_rsp ch%0d: got data %h expected no response", ch, d);
      end else begin
         e = sb[ch].pop_front();
         chk($sformatf("rsp_data ch%0d", ch), d, e.data);
         chk($sformatf("rsp_cycle ch%0d", ch), 128'(cyc), 128'(e.due));
         chk($sformatf("busy_at_rsp ch%0d", ch), 128'(bz), 128'(1));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ks_rsp_valid_a) mon(0, {96'b0, ks_rsp_data_a}, busy_a);
         if (st_rsp_valid_a) mon(1, st_rsp_data_a, busy_a);
         if (ks_rsp_valid_b) mon(2, {96'b0, ks_rsp_data_b}, busy_b);
         if (st_rsp_valid_b) mon(3, st_rsp_data_b, busy_b);
      end
   end

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0) break;
         @(negedge clk);
      end
      for (int ch = 0; ch < 4; ch++)
         chk($sformatf("drain ch%0d", ch), 128'(sb[ch].size()), 128'(0));
   endtask

   int t0, t1, t2;

   initial begin
      rst = 1'b1;
      for (int ch = 0; ch < 4; ch++) set_req(ch, 1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset ks_req_ready", 128'(ks_req_ready_a), 128'(0));
      chk("reset st_req_ready", 128'(st_req_ready_a), 128'(0));
      chk("reset ks_rsp_valid", 128'(ks_rsp_valid_a), 128'(0));
      chk("reset st_rsp_valid", 128'(st_rsp_valid_a), 128'(0));
      chk("reset ks_rsp_data", 128'(ks_rsp_data_a), 128'(0));
      chk("reset st_rsp_data", st_rsp_data_a, 128'(0));
      chk("reset busy", 128'(busy_a), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // both valid from reset: KS wins (last_grant=ST), ST follows 4 cycles later
      fork
         send(0, 1'b0, 128'h0, 128'h63636363, 3, t0);
         send(1, 1'b0, B53, BED, 6, t1);
      join
      chk("arb_first_gap", 128'(t1 - t0), 128'(4));
      fork
         send(0, 1'b0, 128'h03020100, 128'h7b777c63, 3, t0);
         send(1, 1'b1, B52, B48, 6, t1);
      join
      chk("arb_second_gap", 128'(t1 - t0), 128'(4));

      // ST-only stream: one accept every 7 cycles
      send(1, 1'b0, SEQ, SBX, 6, t0);
      send(1, 1'b1, SBX, SEQ, 6, t1);
      send(1, 1'b0, B53, BED, 6, t2);
      chk("st_stream_gap1", 128'(t1 - t0), 128'(7));
      chk("st_stream_gap2", 128'(t2 - t1), 128'(7));
      drain();
      chk("ks_rsp_hold", 128'(ks_rsp_data_a), 128'h7b777c63);

      // single-lane, unpipelined instance
      send(3, 1'b0, SEQ, SBX, 17, t0);
      send(3, 1'b1, B52, B48, 17, t0);
      send(2, 1'b0, 128'h03020100, 128'h7b777c63, 5, t0);
      drain();
      chk("b_st_rsp_hold", st_rsp_data_b, B48);

      // reset in the middle of an ST job
      send(1, 1'b0, SEQ, SBX, 6, t0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 128'h0);
      set_req(1, 1'b1, 1'b0, SEQ);
      #1;
      sb[1].delete();
      chk("midrst busy", 128'(busy_a), 128'(0));
      chk("midrst ks_req_ready", 128'(ks_req_ready_a), 128'(0));
      chk("midrst st_req_ready", 128'(st_req_ready_a), 128'(0));
      chk("midrst st_rsp_valid", 128'(st_rsp_valid_a), 128'(0));
      chk("midrst st_rsp_data", st_rsp_data_a, 128'(0));
      chk("midrst ks_rsp_data", 128'(ks_rsp_data_a), 128'(0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("midrst st_rsp_valid_hold", 128'(st_rsp_valid_a), 128'(0));
      end
      set_req(0, 1'b0, 1'b0, 128'h0);
      set_req(1, 1'b0, 1'b0, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      send(0, 1'b0, 128'h03020100, 128'h7b777c63, 3, t0);
      send(0, 1'b0, 128'h0, 128'h63636363, 3, t0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
